// File: rtl/pcpi_io_pkg.sv
// Shared definitions for the nibble-wide PCPI host link, used by both the
// upstream deserializer and the result serializer.
`default_nettype none

package pcpi_io_pkg;

  localparam int NIB_W_DEF     = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int NIBS_PER_WORD = DATA_W_DEF / NIB_W_DEF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_LOW = 2'd2
  } ser_state_e;

endpackage

`default_nettype wire

// File: rtl/pcpi_result_serializer_result_fifo.sv
// Small first-word-fall-through FIFO that buffers coprocessor results.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
`default_nettype none

module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/pcpi_result_serializer.sv
// Buffers coprocessor results and streams them to the host LSB nibble first
// over a four-phase valid/ack handshake.
`default_nettype none

module pcpi_result_serializer
  import pcpi_io_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NIB_W       = NIB_W_DEF,
  parameter int FIFO_DEPTH  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pcpi_ready,
  input  logic                          pcpi_wr,
  input  logic [DATA_W-1:0]             pcpi_rd,
  input  logic                          host_ack,
  output logic [NIB_W-1:0]              out_nibble,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int NIBS  = DATA_W / NIB_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  logic [1:0]             rst_sync_q, rst_sync_d;
  logic                   rst_int_n;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   ack_s;

  ser_state_e             state_q, state_d;
  logic [DATA_W-1:0]      sr_q, sr_d, sr_shift;
  logic [IDX_W-1:0]       nib_idx_q, nib_idx_d;
  logic [NIB_W-1:0]       out_nibble_q, out_nibble_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   busy_q, busy_d;
  logic                   overflow_q, overflow_d;

  logic                   push, pop;
  logic [DATA_W-1:0]      fifo_head;
  logic                   fifo_full, fifo_empty;

  // Reset asserts immediately but releases on a clock edge.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], host_ack};
  assign ack_s      = ack_sync_q[SYNC_STAGES-1];

  assign push = pcpi_ready && pcpi_wr;

  result_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .push      (push),
    .push_data (pcpi_rd),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign sr_shift = sr_q >> NIB_W;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    nib_idx_d    = nib_idx_q;
    out_nibble_d = out_nibble_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !ack_s) begin
          pop          = 1'b1;
          sr_d         = fifo_head;
          nib_idx_d    = '0;
          out_nibble_d = fifo_head[NIB_W-1:0];
          out_valid_d  = 1'b1;
          out_last_d   = (NIBS == 1);
          state_d      = PRESENT;
        end
      end
      PRESENT: begin
        if (ack_s) begin
          out_valid_d = 1'b0;
          state_d     = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!ack_s) begin
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = IDLE;
          end else begin
            nib_idx_d    = nib_idx_q + 1'b1;
            sr_d         = sr_shift;
            out_nibble_d = sr_shift[NIB_W-1:0];
            out_valid_d  = 1'b1;
            out_last_d   = ((int'(nib_idx_q) + 1) == (NIBS - 1));
            state_d      = PRESENT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only a push that the FIFO actually rejects marks a loss.
  assign overflow_d = overflow_q | (push && fifo_full && !pop);
  assign busy_d     = (fifo_count != '0) || (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ack_sync_q   <= '0;
      state_q      <= IDLE;
      sr_q         <= '0;
      nib_idx_q    <= '0;
      out_nibble_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      ack_sync_q   <= ack_sync_d;
      state_q      <= state_d;
      sr_q         <= sr_d;
      nib_idx_q    <= nib_idx_d;
      out_nibble_q <= out_nibble_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign out_nibble = out_nibble_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_pcpi_result_serializer.sv
// Directed bench for pcpi_result_serializer: capture, handshake, overflow,
// stall and mid-frame reset behaviour with hand-computed expectations.
`default_nettype none

module tb_pcpi_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        host_ack;
  logic [3:0]  out_nibble;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        overflow;
  logic [1:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  pcpi_result_serializer #(
    .DATA_W      (32),
    .NIB_W       (4),
    .FIFO_DEPTH  (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcpi_ready (pcpi_ready),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .host_ack   (host_ack),
    .out_nibble (out_nibble),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [31:0] rd, input logic wr);
    pcpi_ready = 1'b1;
    pcpi_wr    = wr;
    pcpi_rd    = rd;
    tick();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
  endtask

  task automatic wait_valid(input logic lvl, input string tag);
    int k;
    k = 0;
    while (out_valid !== lvl && k < 40) begin
      tick();
      k++;
    end
    check(tag, 32'(out_valid), 32'(lvl));
  endtask

  // Handshakes nibbles first..last of a word, checking data and the last flag.
  task automatic recv_nibbles(input logic [31:0] word, input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      wait_valid(1'b1, {tag, "_valid_hi"});
      check({tag, "_nibble"}, 32'(out_nibble), 32'(word[4*i +: 4]));
      check({tag, "_last"}, 32'(out_last), 32'(i == 7));
      host_ack = 1'b1;
      wait_valid(1'b0, {tag, "_valid_lo"});
      host_ack = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_nibble"},   32'(out_nibble), 32'd0);
    check({tag, "_valid"},    32'(out_valid),  32'd0);
    check({tag, "_last"},     32'(out_last),   32'd0);
    check({tag, "_busy"},     32'(busy),       32'd0);
    check({tag, "_overflow"}, 32'(overflow),   32'd0);
    check({tag, "_count"},    32'(fifo_count), 32'd0);
  endtask

  initial begin
    int changes;
    rst_n      = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    host_ack   = 1'b0;

    // Reset state
    ticks(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    ticks(4);
    check_all_zero("post_reset");

    // Single word and first-valid latency
    strobe(32'h89ABCDEF, 1'b1);
    check("single_count_c1", 32'(fifo_count), 32'd1);
    check("single_valid_c1", 32'(out_valid), 32'd0);
    tick();
    check("single_valid_c2", 32'(out_valid), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    recv_nibbles(32'h89ABCDEF, 0, 7, "single");
    ticks(6);
    check("single_busy_done", 32'(busy), 32'd0);
    check("single_count_done", 32'(fifo_count), 32'd0);

    // Completion without writeback
    strobe(32'h12345678, 1'b0);
    check("nowr_count", 32'(fifo_count), 32'd0);
    ticks(3);
    check("nowr_valid", 32'(out_valid), 32'd0);
    check("nowr_count_later", 32'(fifo_count), 32'd0);

    // Back-to-back strobes, host idle
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = 32'h00000001;
    tick();
    pcpi_rd    = 32'h00000002;
    tick();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    check("b2b_count", 32'(fifo_count), 32'd1);
    check("b2b_valid", 32'(out_valid), 32'd1);
    ticks(4);
    check("b2b_count_hold", 32'(fifo_count), 32'd1);
    recv_nibbles(32'h00000001, 0, 7, "b2b_w1");
    recv_nibbles(32'h00000002, 0, 7, "b2b_w2");
    ticks(6);
    check("b2b_count_done", 32'(fifo_count), 32'd0);

    // Overflow while ack is held high
    host_ack = 1'b1;
    ticks(3);
    strobe(32'h11111111, 1'b1);
    strobe(32'h22222222, 1'b1);
    check("ovf_not_yet", 32'(overflow), 32'd0);
    strobe(32'h33333333, 1'b1);
    check("ovf_count", 32'(fifo_count), 32'd2);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_valid_blocked", 32'(out_valid), 32'd0);
    ticks(5);
    check("ovf_flag_sticky", 32'(overflow), 32'd1);
    host_ack = 1'b0;
    recv_nibbles(32'h11111111, 0, 7, "ovf_w1");
    recv_nibbles(32'h22222222, 0, 7, "ovf_w2");
    ticks(10);
    check("ovf_no_third", 32'(out_valid), 32'd0);
    check("ovf_drained", 32'(fifo_count), 32'd0);
    check("ovf_flag_end", 32'(overflow), 32'd1);

    // Stalled acknowledge in PRESENT
    strobe(32'h76543210, 1'b1);
    wait_valid(1'b1, "stall_valid");
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_nibble !== 4'h0) changes++;
    end
    check("stall_stable", 32'(changes), 32'd0);
    host_ack = 1'b1;
    ticks(2);
    check("stall_valid_2cyc", 32'(out_valid), 32'd1);
    tick();
    check("stall_valid_3cyc", 32'(out_valid), 32'd0);
    host_ack = 1'b0;
    recv_nibbles(32'h76543210, 1, 7, "stall_rest");
    ticks(6);

    // Reset in the middle of a frame
    strobe(32'hDEADBEEF, 1'b1);
    recv_nibbles(32'hDEADBEEF, 0, 2, "mid");
    wait_valid(1'b1, "mid_4th_valid");
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    ticks(2);
    rst_n = 1'b1;
    ticks(4);
    check_all_zero("mid_post_reset");
    strobe(32'h0000000A, 1'b1);
    recv_nibbles(32'h0000000A, 0, 7, "after_reset");
    ticks(6);
    check("after_reset_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
